// File: rtl/aes_round_sequencer_pkg.sv
// rtl/aes_round_sequencer_pkg.sv - shared state encoding, round-count constants and column helper
package aes_ctrl_pkg;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;
  localparam int COLS       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INPUT,
    ST_MID,
    ST_LAST,
    ST_DONE,
    ST_HOLD
  } state_e;

  // Column 0 sits in the most significant word of a block.
  function automatic int col_lsb(input logic [1:0] idx, input int dw);
    return dw * (COLS - 1 - int'(idx));
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - block-in / result-out valid/ready handshake bundle
interface aes_round_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BW = 4 * DATA_WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [BW-1:0] in_block;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_block;

  modport master (
    output in_valid, in_mode, in_block, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_mode, in_block, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/aes_round_sequencer_counter.sv
// rtl/aes_round_sequencer_counter.sv - column-cycle counter with round counter advancing on wrap
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  output logic [1:0] cycle_o,
  output logic [3:0] round_o,
  output logic       wrap_o,
  output logic       mid_end_o
);

  logic [1:0] cycle_q, cycle_d;
  logic [3:0] round_q, round_d;

  always_comb begin
    cycle_d = cycle_q;
    round_d = round_q;
    if (clear_i) begin
      cycle_d = '0;
      round_d = '0;
    end else if (en_i) begin
      cycle_d = cycle_q + 2'd1;
      if (cycle_q == 2'd3) round_d = round_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      round_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      round_q <= round_d;
    end
  end

  assign cycle_o   = cycle_q;
  assign round_o   = round_q;
  assign wrap_o    = en_i && (cycle_q == 2'd3);
  assign mid_end_o = (round_q == 4'(NR - 1));

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - sequences the column-serial AES datapath through its rounds
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR         = AES_NR_128,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  aes_round_sequencer_if.slave    bus,
  output logic [3:0]              key_round_o,
  output logic [1:0]              key_word_o,
  input  logic [DATA_WIDTH-1:0]   key_data_i,
  output logic [1:0]              count_cycle_o,
  output logic                    mode_o,
  output logic                    input_round_o,
  output logic                    last_round_o,
  output logic                    done_round_o,
  output logic                    idle_round_o,
  output logic [DATA_WIDTH-1:0]   input_data_o,
  output logic [DATA_WIDTH-1:0]   round_key_o,
  input  logic [DATA_WIDTH-1:0]   dp_output_i
);

  localparam int BW = COLS * DATA_WIDTH;

  if (NR != AES_NR_128 && NR != AES_NR_192 && NR != AES_NR_256) begin : g_nr_check
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  state_e        state_q, state_d;
  logic [BW-1:0] blk_q, out_block_q;
  logic          mode_q;
  logic          accept, busy, wrap, mid_end;
  logic [1:0]    cycle;
  logic [3:0]    round;

  aes_round_counter #(.NR(NR)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept),
    .en_i      (busy),
    .cycle_o   (cycle),
    .round_o   (round),
    .wrap_o    (wrap),
    .mid_end_o (mid_end)
  );

  assign busy = (state_q == ST_INPUT) || (state_q == ST_MID) ||
                (state_q == ST_LAST)  || (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.in_valid) begin
                  accept  = 1'b1;
                  state_d = ST_INPUT;
                end
      ST_INPUT: if (wrap) state_d = ST_MID;
      ST_MID:   if (wrap && mid_end) state_d = ST_LAST;
      ST_LAST:  if (wrap) state_d = ST_DONE;
      ST_DONE:  if (wrap) state_d = ST_HOLD;
      ST_HOLD:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      mode_q      <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        blk_q  <= bus.in_block;
        mode_q <= bus.in_mode;
      end
      if (state_q == ST_DONE)
        out_block_q[col_lsb(cycle, DATA_WIDTH) +: DATA_WIDTH] <= dp_output_i;
    end
  end

  // Decryption walks the key schedule backwards: round r uses key NR-r.
  always_comb begin
    key_round_o = '0;
    if (state_q == ST_INPUT || state_q == ST_MID || state_q == ST_LAST)
      key_round_o = mode_q ? round : (4'(NR) - round);
  end

  assign key_word_o    = cycle;
  assign round_key_o   = key_data_i;
  assign count_cycle_o = cycle;
  assign mode_o        = mode_q;
  assign input_round_o = (state_q == ST_INPUT);
  assign last_round_o  = (state_q == ST_LAST);
  assign done_round_o  = (state_q == ST_DONE);
  assign idle_round_o  = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign input_data_o  = (state_q == ST_INPUT) ? blk_q[col_lsb(cycle, DATA_WIDTH) +: DATA_WIDTH] : '0;

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_block = out_block_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed self-checking bench for aes_round_sequencer
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_round;
  logic [1:0]  key_word;
  logic [31:0] key_data;
  logic [1:0]  count_cycle;
  logic        mode, input_round, last_round, done_round, idle_round;
  logic [31:0] input_data, round_key, dp_output;
  logic [127:0] exp_res = '0;
  int errs = 0;
  int checks = 0;

  aes_round_sequencer_if #(.DATA_WIDTH(32)) bus ();

  aes_round_sequencer #(.NR(NR), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .key_round_o   (key_round),
    .key_word_o    (key_word),
    .key_data_i    (key_data),
    .count_cycle_o (count_cycle),
    .mode_o        (mode),
    .input_round_o (input_round),
    .last_round_o  (last_round),
    .done_round_o  (done_round),
    .idle_round_o  (idle_round),
    .input_data_o  (input_data),
    .round_key_o   (round_key),
    .dp_output_i   (dp_output)
  );

  always #5 clk = ~clk;

  // Key store and datapath stand-ins: the datapath returns the expected result column.
  assign key_data  = {16'hC0DE, 4'h0, key_round, 6'h0, key_word};
  assign dp_output = done_round ? 32'(exp_res >> (32 * (3 - int'(count_cycle)))) : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ctl"}, 128'({bus.in_ready, bus.out_valid, idle_round, input_round, last_round,
                             done_round, count_cycle, mode, key_round}),
        128'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0}));
    chk({tag, " out_block"}, bus.out_block, 128'd0);
    chk({tag, " input_data"}, 128'(input_data), 128'd0);
  endtask

  task automatic run_block(input logic m, input logic [127:0] blk, input logic [127:0] res,
                           input int stall, input logic keep_valid);
    int phase, cc;
    logic [3:0] f, kr;
    logic [31:0] idat;
    chk("in_ready before accept", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_block = blk;
    exp_res      = res;
    tick();
    bus.in_valid = keep_valid;
    bus.in_mode  = ~m;
    bus.in_block = ~blk;
    for (int k = 0; k < 4 * (NR + 2); k++) begin
      phase = k / 4;
      cc    = k % 4;
      f  = (phase == 0) ? 4'b1000 : (phase == NR) ? 4'b0100 : (phase == NR + 1) ? 4'b0010 : 4'b0000;
      kr = (phase <= NR) ? (m ? 4'(phase) : 4'(NR - phase)) : 4'd0;
      idat = (phase == 0) ? 32'(blk >> (32 * (3 - cc))) : 32'd0;
      chk($sformatf("ctl k=%0d", k),
          128'({input_round, last_round, done_round, idle_round, count_cycle, key_round, key_word,
                mode, bus.in_ready, bus.out_valid}),
          128'({f, 2'(cc), kr, 2'(cc), m, 1'b0, 1'b0}));
      chk($sformatf("input_data k=%0d", k), 128'(input_data), 128'(idat));
      chk($sformatf("round_key k=%0d", k), 128'(round_key), 128'(key_data));
      if (k == 4 * (NR + 2) - 1 && stall == 0) bus.out_ready = 1'b1;
      tick();
    end
    chk("out_valid at latency", 128'(bus.out_valid), 128'(1));
    chk("out_block result", bus.out_block, res);
    chk("hold idle/in_ready", 128'({idle_round, bus.in_ready}), 128'(2'b10));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk($sformatf("stall s=%0d valid/ready", s), 128'({bus.out_valid, bus.in_ready}), 128'(2'b10));
      chk($sformatf("stall s=%0d out_block", s), bus.out_block, res);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid falls", 128'(bus.out_valid), 128'(0));
    chk("out_block kept", bus.out_block, res);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b0;
    tick();
    chk_reset_state("reset");
    tick();
    rst = 1'b0;
    tick();

    run_block(1'b1, PT, CT, 0, 1'b0);
    run_block(1'b0, CT, PT, 0, 1'b0);
    run_block(1'b1, PT, CT, 20, 1'b0);

    run_block(1'b1, PT, CT, 0, 1'b1);
    run_block(1'b0, ~PT, PT ^ CT, 0, 1'b0);

    bus.in_valid = 1'b1;
    bus.in_mode  = 1'b1;
    bus.in_block = PT;
    exp_res      = CT;
    tick();
    bus.in_valid = 1'b0;
    repeat (17) tick();
    chk("mid-flight count_cycle", 128'({count_cycle, input_round, idle_round}), 128'({2'd1, 1'b0, 1'b0}));
    #2 rst = 1'b1;
    #1;
    chk_reset_state("async reset");
    tick();
    rst = 1'b0;
    tick();
    run_block(1'b1, PT, CT, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
